// File: rtl/secded_pkg.sv
// Shared definitions for the Hamming SECDED encoder/decoder pair.
//   state_t        : encoder FSM states (S_CKSUM exists only when
//                    SECDED_ENC_CHECKSUM_EN is defined)
//   msg_t          : 11-bit message, d[11:1]
//   cw_t           : 16-bit codeword
//   secded_encode  : msg_t -> cw_t, the reference codeword layout
//                    {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}
package secded_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
`ifdef SECDED_ENC_CHECKSUM_EN
        S_CKSUM = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_t;

    typedef logic [11:1] msg_t;
    typedef logic [15:0] cw_t;

    function automatic cw_t secded_encode(input msg_t d);
        logic p8;
        logic p4;
        logic p2;
        logic p1;
        logic p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        // p0 covers the whole codeword, so a single flip always toggles it
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/secded_parity_gen.sv
// Combinational SECDED parity generator.
//   msg : input  msg_t, data bits d[11:1]
//   cw  : output cw_t, encoded 16-bit codeword
module secded_parity_gen
    import secded_pkg::*;
(
    input  msg_t msg,
    output cw_t  cw
);

    assign cw = secded_encode(msg);

endmodule

// File: rtl/secded_encoder.sv
// Memory-walking SECDED encoder. On req, reads NUM_MSG two-byte messages
// starting at SRC_BASE, writes the two-byte codewords starting at DST_BASE,
// then holds done until the next req.
// Optional macro SECDED_ENC_CHECKSUM_EN: after the last codeword, writes the
// XOR of all codeword bytes to DST_BASE + 2*NUM_MSG.
//
//   clk          : in  clock, rising edge
//   rst_n        : in  asynchronous active-low reset
//   req          : in  start request (IDLE / DONE only)
//   done         : out run complete, level
//   mem_addr     : out data-memory byte address
//   mem_rd_data  : in  read data, combinational in mem_addr
//   mem_wr_en    : out write strobe
//   mem_wr_data  : out write data
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for req after reset
// S_RD_LO | reading message low byte d[8:1]
// S_RD_HI | reading message high byte d[11:9]
// S_WR_LO | writing cw[7:0]
// S_WR_HI | writing cw[15:8], advance or finish
// S_CKSUM | writing XOR checksum (checksum build only)
// S_DONE  | done high, req restarts
module secded_encoder
    import secded_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    lo_byte;
    logic [2:0]    hi_bits;
    msg_t          msg;
    cw_t           cw;
    logic [AW-1:0] src_lo;
    logic [AW-1:0] dst_lo;

`ifdef SECDED_ENC_CHECKSUM_EN
    logic [7:0]    cksum;
`endif

    assign msg    = {hi_bits, lo_byte};
    assign src_lo = AW'(SRC_BASE) + AW'({idx, 1'b0});
    assign dst_lo = AW'(DST_BASE) + AW'({idx, 1'b0});

    secded_parity_gen u_parity_gen (
        .msg (msg),
        .cw  (cw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            lo_byte <= '0;
            hi_bits <= '0;
            done    <= 1'b0;
`ifdef SECDED_ENC_CHECKSUM_EN
            cksum   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        state <= S_RD_LO;
                        idx   <= '0;
                        done  <= 1'b0;
`ifdef SECDED_ENC_CHECKSUM_EN
                        cksum <= '0;
`endif
                    end
                end
                S_RD_LO: begin
                    lo_byte <= mem_rd_data;
                    state   <= S_RD_HI;
                end
                S_RD_HI: begin
                    // bits [7:3] of the high byte are don't-care input
                    hi_bits <= mem_rd_data[2:0];
                    state   <= S_WR_LO;
                end
                S_WR_LO: begin
`ifdef SECDED_ENC_CHECKSUM_EN
                    cksum <= cksum ^ cw[7:0];
`endif
                    state <= S_WR_HI;
                end
                S_WR_HI: begin
`ifdef SECDED_ENC_CHECKSUM_EN
                    cksum <= cksum ^ cw[15:8];
`endif
                    if (idx == LAST_IDX) begin
`ifdef SECDED_ENC_CHECKSUM_EN
                        state <= S_CKSUM;
`else
                        state <= S_DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= S_RD_LO;
                    end
                end
`ifdef SECDED_ENC_CHECKSUM_EN
                S_CKSUM: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory port decodes from registered state only; no read-to-output path.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            S_RD_LO: mem_addr = src_lo;
            S_RD_HI: mem_addr = src_lo + AW'(1);
            S_WR_LO: begin
                mem_addr    = dst_lo;
                mem_wr_en   = 1'b1;
                mem_wr_data = cw[7:0];
            end
            S_WR_HI: begin
                mem_addr    = dst_lo + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = cw[15:8];
            end
`ifdef SECDED_ENC_CHECKSUM_EN
            S_CKSUM: begin
                mem_addr    = AW'(DST_BASE + 2 * NUM_MSG);
                mem_wr_en   = 1'b1;
                mem_wr_data = cksum;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_secded_encoder.sv
// Self-checking bench for secded_encoder (default parameters).
// Honours SECDED_ENC_CHECKSUM_EN when the design is built with it.
module tb_secded_encoder;

    localparam int NUM_MSG = 15;
    localparam int DST     = 30;
`ifdef SECDED_ENC_CHECKSUM_EN
    localparam int DONE_CYC = 62;
    localparam int N_WR     = 31;
`else
    localparam int DONE_CYC = 61;
    localparam int N_WR     = 30;
`endif

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] init_mem [256];
    logic [7:0] wr_mem   [256];
    logic       wr_seen  [256];
    int         wr_count;
    logic       clr;

    int n_cmp  = 0;
    int n_fail = 0;

    secded_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = init_mem[mem_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int a = 0; a < 256; a++) begin
                wr_mem[a]  <= 8'h00;
                wr_seen[a] <= 1'b0;
            end
            wr_count <= 0;
        end else if (mem_wr_en) begin
            wr_mem[mem_addr]  <= mem_wr_data;
            wr_seen[mem_addr] <= 1'b1;
            wr_count          <= wr_count + 1;
        end
    end

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Independent positional Hamming model: data fills non-power-of-two
    // positions 3..15 in order, parity at 1,2,4,8, overall parity in bit 0.
    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] c;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            logic x;
            x = 1'b0;
            for (int p = 1; p < 16; p++)
                if (p[j]) x = x ^ c[p];
            c[1 << j] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [12:0] ref_decode(input logic [15:0] c);
        logic [3:0] s;
        logic [1:0] st;
        s = '0;
        for (int p = 1; p < 16; p++)
            if (c[p]) s = s ^ p[3:0];
        if (s == 4'd0 && !(^c)) st = 2'b00;
        else if (^c)            st = 2'b01;
        else                    st = 2'b10;
        return {st, c[15:9], c[7:5], c[3]};
    endfunction

    task automatic clear_writes();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic zero_src();
        for (int a = 0; a < 256; a++) init_mem[a] = 8'h00;
    endtask

    // Pulses req, returns the cycle (1 = RD_LO cycle) in which done is first
    // seen. A req pulse is optionally injected during the run.
    task automatic run(input int pulse_at, output int cyc);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        req = 1'b0;
        while (!done && cyc < 300) begin
            req = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [15:0] c;
        logic [12:0] dec;
        for (int i = 0; i < NUM_MSG; i++) begin
            c   = ref_encode({init_mem[2*i+1][2:0], init_mem[2*i]});
            dec = ref_decode({wr_mem[DST+2*i+1], wr_mem[DST+2*i]});
            check($sformatf("%s cw%0d_lo", tag, i), 32'(wr_mem[DST+2*i]),   32'(c[7:0]));
            check($sformatf("%s cw%0d_hi", tag, i), 32'(wr_mem[DST+2*i+1]), 32'(c[15:8]));
            check($sformatf("%s rt%0d", tag, i), 32'(dec),
                  32'({2'b00, init_mem[2*i+1][2:0], init_mem[2*i]}));
        end
    endtask

    initial begin
        int cyc;
        int saved;
        vecs[0] = '{lo: 8'h01, hi: 8'h00, exp_lo: 8'h0F, exp_hi: 8'h00};
        vecs[1] = '{lo: 8'h00, hi: 8'h04, exp_lo: 8'h17, exp_hi: 8'h81};
        vecs[2] = '{lo: 8'hFF, hi: 8'hFF, exp_lo: 8'hFF, exp_hi: 8'hFF};
        vecs[3] = '{lo: 8'h00, hi: 8'hF8, exp_lo: 8'h00, exp_hi: 8'h00};
        vecs[4] = '{lo: 8'h02, hi: 8'h00, exp_lo: 8'h33, exp_hi: 8'h00};
        vecs[5] = '{lo: 8'h00, hi: 8'h00, exp_lo: 8'h00, exp_hi: 8'h00};

        rst_n = 1'b0;
        req   = 1'b0;
        clr   = 1'b1;
        zero_src();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst done",    32'(done),        32'h0);
        check("rst wr_en",   32'(mem_wr_en),   32'h0);
        check("rst addr",    32'(mem_addr),    32'h0);
        check("rst wr_data", 32'(mem_wr_data), 32'h0);
        rst_n = 1'b1;
        clr   = 1'b0;

        // all-zero messages
        clear_writes();
        run(-1, cyc);
        check("zero done_cycle", 32'(cyc), 32'(DONE_CYC));
        repeat (3) @(negedge clk);
        check("zero done_hold", 32'(done), 32'h1);
        check("zero wr_count", 32'(wr_count), 32'(N_WR));
        for (int a = DST; a < DST + 2 * NUM_MSG; a++)
            check($sformatf("zero byte%0d", a), 32'(wr_mem[a]), 32'h0);
`ifndef SECDED_ENC_CHECKSUM_EN
        check("zero no_extra_write", 32'(wr_seen[DST + 2 * NUM_MSG]), 32'h0);
`endif

        // table vectors + random fill, with an ignored mid-run req pulse
        for (int i = 0; i < NUM_MSG; i++) begin
            init_mem[2*i]   = 8'($random);
            init_mem[2*i+1] = 8'($random);
        end
        for (int v = 0; v < 6; v++) begin
            init_mem[2*v]   = vecs[v].lo;
            init_mem[2*v+1] = vecs[v].hi;
        end
        clear_writes();
        run(10, cyc);
        check("tbl done_cycle", 32'(cyc), 32'(DONE_CYC));
        check("tbl wr_count", 32'(wr_count), 32'(N_WR));
        for (int v = 0; v < 6; v++) begin
            check($sformatf("vec%0d lo", v), 32'(wr_mem[DST+2*v]),   32'(vecs[v].exp_lo));
            check($sformatf("vec%0d hi", v), 32'(wr_mem[DST+2*v+1]), 32'(vecs[v].exp_hi));
        end
        check_all("tbl");

        // back-to-back: req held while done is high restarts immediately
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("b2b done_drop", 32'(done), 32'h0);
        check("b2b rd_addr",   32'(mem_addr), 32'h0);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b done_cycle", 32'(cyc), 32'(DONE_CYC));

        // reset in the middle of a run
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (19) @(negedge clk);
        saved = wr_count;
        rst_n = 1'b0;
        #1;
        check("midrst done",    32'(done),        32'h0);
        check("midrst wr_en",   32'(mem_wr_en),   32'h0);
        check("midrst addr",    32'(mem_addr),    32'h0);
        check("midrst wr_data", 32'(mem_wr_data), 32'h0);
        @(negedge clk);
        check("midrst no_writes", 32'(wr_count), 32'(saved));
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst idle", 32'(mem_addr), 32'h0);
        clear_writes();
        run(-1, cyc);
        check("rerun done_cycle", 32'(cyc), 32'(DONE_CYC));
        check_all("rerun");

`ifdef SECDED_ENC_CHECKSUM_EN
        zero_src();
        init_mem[0] = 8'h01;
        init_mem[3] = 8'h04;
        clear_writes();
        run(-1, cyc);
        check("cksum done_cycle", 32'(cyc), 32'd62);
        check("cksum byte", 32'(wr_mem[DST + 2 * NUM_MSG]), 32'h99);
        check("cksum wr_count", 32'(wr_count), 32'd31);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
